inv_add_round_key: RTL

INV_ADD_ROUND_KEY -- requirements
Module: inv_add_round_key

---
 rtl/inv_add_round_key_pkg.sv | 15 +
 rtl/inv_add_round_key_skid.sv | 41 ++++
 rtl/inv_add_round_key.sv | 123 ++++++++++++
 3 files changed

// File: rtl/inv_add_round_key_pkg.sv
// Shared types and constants for the inverse AddRoundKey stage of AES-128 decryption.
package inv_add_round_key_pkg;

    localparam int         RND_W  = 4;
    localparam logic [3:0] AES_NR = 4'd10;

    typedef logic [127:0]     aes_state_t;
    typedef logic [RND_W-1:0] rnd_t;

    // InvMixColumns is skipped for the initial (10) and final (0) rounds.
    function automatic logic ark_mix_en(input rnd_t rnd);
        return (rnd >= 4'd1) && (rnd <= 4'd9);
    endfunction

endpackage

// File: rtl/inv_add_round_key_skid.sv
// One-entry skid buffer (valid + 128-bit state + 4-bit round) for inv_add_round_key.
module ark_skid_buf
    import inv_add_round_key_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  aes_state_t i_state,
    input  rnd_t       i_round,
    output logic       o_valid,
    output aes_state_t o_state,
    output rnd_t       o_round
);

    logic       r_valid;
    aes_state_t r_state;
    rnd_t       r_round;

    // Capture a beat that could not enter the stalled output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_state <= 128'd0;
            r_round <= 4'd0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_state <= i_state;
            r_round <= i_round;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_state = r_state;
    assign o_round = r_round;

endmodule

// File: rtl/inv_add_round_key.sv
// Inverse AddRoundKey stage: XORs the state with the round key and tracks rounds 10..0.
// Optional 1-entry skid buffer enabled by defining INV_ARK_SKID_EN.
module inv_add_round_key
    import inv_add_round_key_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_start,
    input  logic [127:0] in_state,
    output logic [3:0]   key_idx,
    input  logic [127:0] in_round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_mix_en,
    output logic         out_last,
    output logic         out_abort
);

    rnd_t       r_cnt;
    logic       r_out_valid;
    aes_state_t r_out_state;
    rnd_t       r_out_round;
    logic       r_out_mix_en;
    logic       r_out_last;
    logic       r_out_abort;

    logic       w_acc;
    logic       w_out_free;
    aes_state_t w_new_state;
    logic       w_load_valid;
    aes_state_t w_load_state;
    rnd_t       w_load_round;

    // An idle counter or an explicit start both begin a block at round 10.
    assign key_idx     = (in_start || (r_cnt == AES_NR)) ? AES_NR : r_cnt;
    assign w_acc       = in_valid && in_ready;
    assign w_new_state = in_state ^ in_round_key;
    assign w_out_free  = !r_out_valid || out_ready;

`ifdef INV_ARK_SKID_EN
    logic       w_sk_valid;
    aes_state_t w_sk_state;
    rnd_t       w_sk_round;

    ark_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_acc && !w_out_free),
        .i_pop   (w_out_free && w_sk_valid),
        .i_state (w_new_state),
        .i_round (key_idx),
        .o_valid (w_sk_valid),
        .o_state (w_sk_state),
        .o_round (w_sk_round)
    );

    // A full skid entry blocks input, so it never races a new beat for the output register.
    assign in_ready     = !w_sk_valid;
    assign w_load_valid = w_sk_valid || w_acc;
    assign w_load_state = w_sk_valid ? w_sk_state : w_new_state;
    assign w_load_round = w_sk_valid ? w_sk_round : key_idx;
`else
    assign in_ready     = w_out_free;
    assign w_load_valid = w_acc;
    assign w_load_state = w_new_state;
    assign w_load_round = key_idx;
`endif

    // Round counter: step down per accepted beat, reload to idle after round 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= AES_NR;
        end else if (w_acc) begin
            r_cnt <= (key_idx == 4'd0) ? AES_NR : (key_idx - 4'd1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Abort pulse for one cycle after a start beat interrupts a running block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_abort <= 1'b0;
        end else begin
            r_out_abort <= w_acc && in_start && (r_cnt != AES_NR);
        end
    end

    // Output register: load when free, otherwise hold the stalled beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_state  <= 128'd0;
            r_out_round  <= 4'd0;
            r_out_mix_en <= 1'b0;
            r_out_last   <= 1'b0;
        end else if (w_out_free) begin
            r_out_valid <= w_load_valid;
            if (w_load_valid) begin
                r_out_state  <= w_load_state;
                r_out_round  <= w_load_round;
                r_out_mix_en <= ark_mix_en(w_load_round);
                r_out_last   <= (w_load_round == 4'd0);
            end else begin
                r_out_state  <= r_out_state;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_state  = r_out_state;
    assign out_round  = r_out_round;
    assign out_mix_en = r_out_mix_en;
    assign out_last   = r_out_last;
    assign out_abort  = r_out_abort;

endmodule
